pc_sequencer: RTL and testbench

- Owns the program counter register and sequences instruction fetch through a req/ack handshake with instruction memory.
- Applies next-PC selection with priority halt > branch > sequential increment, and handles stall, branch flush and halt/resume.
- Sits between the decode/branch unit and the instruction memory port in the control path.

---
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and sequences instruction fetch through
// a req/ack handshake with instruction memory. Next-PC priority within FETCH is
// halt > branch > stall > ack > wait.
//
// Optional feature macro: FETCH_TIMEOUT_EN. When defined, a wait counter halts the
// sequencer and raises a sticky o_fetch_timeout after TIMEOUT_CYCLES unanswered
// request cycles. When undefined, no counter is built and o_fetch_timeout is 0.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst_n          synchronous active-low reset
//   i_halt           stop fetching and hold PC
//   i_resume         leave HALTED
//   i_branch         redirect PC to i_branch_addr (instruction aligned)
//   i_branch_addr    branch target
//   i_stall          downstream busy: hold PC, drop request
//   o_imem_req       fetch request
//   o_imem_addr      fetch address, always equal to o_pc
//   i_imem_ack       memory completes current request this cycle
//   o_pc             current PC register
//   o_inst_valid     one-cycle pulse after a completed fetch
//   o_inst_addr      address of the completed fetch
//   o_halted         high while HALTED
//   o_fetch_timeout  sticky timeout flag
module pc_sequencer #(
    parameter int unsigned                INST_ADDR_WIDTH   = 16,
    parameter int unsigned                NUM_BYTES_IN_INST = 2,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_VECTOR      = '0,
    parameter int unsigned                TIMEOUT_CYCLES    = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_halt,
    input  logic                       i_resume,
    input  logic                       i_branch,
    input  logic [INST_ADDR_WIDTH-1:0] i_branch_addr,
    input  logic                       i_stall,
    output logic                       o_imem_req,
    output logic [INST_ADDR_WIDTH-1:0] o_imem_addr,
    input  logic                       i_imem_ack,
    output logic [INST_ADDR_WIDTH-1:0] o_pc,
    output logic                       o_inst_valid,
    output logic [INST_ADDR_WIDTH-1:0] o_inst_addr,
    output logic                       o_halted,
    output logic                       o_fetch_timeout
);

    localparam int unsigned ALIGN_BITS = $clog2(NUM_BYTES_IN_INST);
    localparam logic [INST_ADDR_WIDTH-1:0] ALIGN_MASK = {INST_ADDR_WIDTH{1'b1}} << ALIGN_BITS;
    localparam logic [INST_ADDR_WIDTH-1:0] PC_INC = INST_ADDR_WIDTH'(NUM_BYTES_IN_INST);

    typedef enum logic [1:0] {StIdle, StFetch, StHalted} state_t;

    state_t                       r_state;
    logic [INST_ADDR_WIDTH-1:0]   r_pc;
    logic                         r_inst_valid;
    logic [INST_ADDR_WIDTH-1:0]   r_inst_addr;
    logic [INST_ADDR_WIDTH-1:0]   w_branch_target;

    assign w_branch_target = i_branch_addr & ALIGN_MASK;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_fetch_timeout;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_pc         <= RESET_VECTOR;
            r_inst_valid <= 1'b0;
            r_inst_addr  <= '0;
`ifdef FETCH_TIMEOUT_EN
            r_wait_cnt      <= '0;
            r_fetch_timeout <= 1'b0;
`endif
        end else begin
            r_inst_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            // Cleared unless this cycle is an unanswered request.
            r_wait_cnt <= '0;
`endif
            case (r_state)
                StIdle: begin
                    if (i_halt) begin
                        r_state <= StHalted;
                    end else begin
                        if (i_branch) r_pc <= w_branch_target;
                        r_state <= StFetch;
                    end
                end
                StFetch: begin
                    if (i_halt) begin
                        r_state <= StHalted;
                    end else if (i_branch) begin
                        // Flush: a coincident ack belongs to the old path.
                        r_pc <= w_branch_target;
                    end else if (i_stall) begin
                        r_pc <= r_pc;
                    end else if (i_imem_ack) begin
                        r_inst_addr  <= r_pc;
                        r_inst_valid <= 1'b1;
                        r_pc         <= r_pc + PC_INC;
                    end else begin
`ifdef FETCH_TIMEOUT_EN
                        if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            r_fetch_timeout <= 1'b1;
                            r_state         <= StHalted;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
`endif
                    end
                end
                StHalted: begin
                    if (i_resume && !i_halt) r_state <= StFetch;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_imem_req   = (r_state == StFetch) && !i_stall;
    assign o_imem_addr  = r_pc;
    assign o_pc         = r_pc;
    assign o_inst_valid = r_inst_valid;
    assign o_inst_addr  = r_inst_addr;
    assign o_halted     = (r_state == StHalted);
`ifdef FETCH_TIMEOUT_EN
    assign o_fetch_timeout = r_fetch_timeout;
`else
    assign o_fetch_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, halt, resume, branch, stall, ack;
    logic [15:0] baddr;
    logic        req, iv, halted, tmo;
    logic [15:0] addr, pc, ia;

`ifdef FETCH_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    always #5 clk = ~clk;

    pc_sequencer #(
        .INST_ADDR_WIDTH  (16),
        .NUM_BYTES_IN_INST(2),
        .RESET_VECTOR     (16'h0000),
        .TIMEOUT_CYCLES   (4)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_halt         (halt),
        .i_resume       (resume),
        .i_branch       (branch),
        .i_branch_addr  (baddr),
        .i_stall        (stall),
        .o_imem_req     (req),
        .o_imem_addr    (addr),
        .i_imem_ack     (ack),
        .o_pc           (pc),
        .o_inst_valid   (iv),
        .o_inst_addr    (ia),
        .o_halted       (halted),
        .o_fetch_timeout(tmo)
    );

    typedef struct {
        logic        rst_n, halt, resume, branch;
        logic [15:0] baddr;
        logic        stall, ack;
        logic        e_req;
        logic [15:0] e_pc;
        logic        e_iv;
        logic [15:0] e_ia;
        logic        e_h, e_t;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_applied = 0;
    int   n_fail = 0;

    // Inputs (rst_n halt resume branch baddr stall ack) and expected outputs
    // during that same cycle (req pc inst_valid inst_addr halted timeout).
    function automatic vec_t mk(logic r, logic h, logic rs, logic b, logic [15:0] ba,
                                logic s, logic a, logic er, logic [15:0] ep, logic ev,
                                logic [15:0] ea, logic eh, logic et);
        vec_t v;
        v.rst_n = r; v.halt = h; v.resume = rs; v.branch = b; v.baddr = ba;
        v.stall = s; v.ack = a; v.e_req = er; v.e_pc = ep; v.e_iv = ev;
        v.e_ia = ea; v.e_h = eh; v.e_t = et;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst_n = v.rst_n; halt = v.halt; resume = v.resume; branch = v.branch;
        baddr = v.baddr; stall = v.stall; ack = v.ack;
    endtask

    task automatic check(input int idx);
        vec_t e;
        e = exp_q.pop_front();
        n_applied++;
        if (req !== e.e_req || pc !== e.e_pc || addr !== e.e_pc || iv !== e.e_iv ||
            ia !== e.e_ia || halted !== e.e_h || tmo !== e.e_t) begin
            n_fail++;
            $display("FAIL vec%0d: got req=%b pc=%h addr=%h iv=%b ia=%h h=%b t=%b, want req=%b pc=%h addr=%h iv=%b ia=%h h=%b t=%b",
                     idx, req, pc, addr, iv, ia, halted, tmo,
                     e.e_req, e.e_pc, e.e_pc, e.e_iv, e.e_ia, e.e_h, e.e_t);
        end
    endtask

    initial begin
        // Sequential fetch, ack every cycle
        vecs.push_back(mk(1,0,0,0,16'h0,0,0, 0,16'h0000,0,16'h0000,0,0)); // 0 IDLE after reset
        vecs.push_back(mk(1,0,0,0,16'h0,0,1, 1,16'h0000,0,16'h0000,0,0)); // 1
        vecs.push_back(mk(1,0,0,0,16'h0,0,1, 1,16'h0002,1,16'h0000,0,0)); // 2
        vecs.push_back(mk(1,0,0,0,16'h0,0,1, 1,16'h0004,1,16'h0002,0,0)); // 3
        vecs.push_back(mk(1,0,0,0,16'h0,0,1, 1,16'h0006,1,16'h0004,0,0)); // 4
        vecs.push_back(mk(1,0,0,0,16'h0,0,0, 1,16'h0008,1,16'h0006,0,0)); // 5 wait
        vecs.push_back(mk(1,0,0,0,16'h0,0,0, 1,16'h0008,0,16'h0006,0,0)); // 6 wait
        // Branch with coincident ack: flush, aligned target
        vecs.push_back(mk(1,0,0,1,16'h0123,0,1, 1,16'h0008,0,16'h0006,0,0)); // 7
        vecs.push_back(mk(1,0,0,0,16'h0,0,0, 1,16'h0122,0,16'h0006,0,0)); // 8
        vecs.push_back(mk(1,0,0,0,16'h0,0,1, 1,16'h0122,0,16'h0006,0,0)); // 9
        // Stall three cycles with ack held high
        vecs.push_back(mk(1,0,0,0,16'h0,1,1, 0,16'h0124,1,16'h0122,0,0)); // 10
        vecs.push_back(mk(1,0,0,0,16'h0,1,1, 0,16'h0124,0,16'h0122,0,0)); // 11
        vecs.push_back(mk(1,0,0,0,16'h0,1,1, 0,16'h0124,0,16'h0122,0,0)); // 12
        vecs.push_back(mk(1,0,0,0,16'h0,0,1, 1,16'h0124,0,16'h0122,0,0)); // 13
        vecs.push_back(mk(1,0,0,1,16'h0010,0,0, 1,16'h0126,1,16'h0124,0,0)); // 14
        // Halt with ack, branch/ack ignored while halted, resume
        vecs.push_back(mk(1,1,0,0,16'h0,0,1, 1,16'h0010,0,16'h0124,0,0)); // 15
        vecs.push_back(mk(1,0,0,1,16'h5555,0,1, 0,16'h0010,0,16'h0124,1,0)); // 16
        vecs.push_back(mk(1,1,1,0,16'h0,0,0, 0,16'h0010,0,16'h0124,1,0)); // 17
        vecs.push_back(mk(1,0,1,0,16'h0,0,0, 0,16'h0010,0,16'h0124,1,0)); // 18
        vecs.push_back(mk(1,0,0,0,16'h0,0,1, 1,16'h0010,0,16'h0124,0,0)); // 19
        // Wrap from FFFE to 0000
        vecs.push_back(mk(1,0,0,1,16'hFFFF,0,0, 1,16'h0012,1,16'h0010,0,0)); // 20
        vecs.push_back(mk(1,0,0,0,16'h0,0,1, 1,16'hFFFE,0,16'h0010,0,0)); // 21
        // Four unanswered request cycles
        vecs.push_back(mk(1,0,0,0,16'h0,0,0, 1,16'h0000,1,16'hFFFE,0,0)); // 22
        vecs.push_back(mk(1,0,0,0,16'h0,0,0, 1,16'h0000,0,16'hFFFE,0,0)); // 23
        vecs.push_back(mk(1,0,0,0,16'h0,0,0, 1,16'h0000,0,16'hFFFE,0,0)); // 24
        vecs.push_back(mk(1,0,0,0,16'h0,0,0, 1,16'h0000,0,16'hFFFE,0,0)); // 25
        vecs.push_back(mk(1,0,0,0,16'h0,0,0, !TMO,16'h0000,0,16'hFFFE,TMO,TMO)); // 26
        vecs.push_back(mk(1,0,1,0,16'h0,0,0, !TMO,16'h0000,0,16'hFFFE,TMO,TMO)); // 27
        vecs.push_back(mk(1,0,0,0,16'h0,0,1, 1,16'h0000,0,16'hFFFE,0,TMO)); // 28
        // Reset mid-fetch
        vecs.push_back(mk(0,0,0,0,16'h0,0,1, 1,16'h0002,1,16'h0000,0,TMO)); // 29
        vecs.push_back(mk(1,0,0,0,16'h0,0,0, 0,16'h0000,0,16'h0000,0,0)); // 30
        // Reset while halted, then branch from IDLE
        vecs.push_back(mk(1,1,0,0,16'h0,0,0, 1,16'h0000,0,16'h0000,0,0)); // 31
        vecs.push_back(mk(0,0,0,0,16'h0,0,0, 0,16'h0000,0,16'h0000,1,0)); // 32
        vecs.push_back(mk(1,0,0,1,16'h0041,0,0, 0,16'h0000,0,16'h0000,0,0)); // 33
        vecs.push_back(mk(1,0,0,0,16'h0,0,1, 1,16'h0040,0,16'h0000,0,0)); // 34
        vecs.push_back(mk(1,0,0,0,16'h0,0,0, 1,16'h0042,1,16'h0040,0,0)); // 35

        rst_n = 1'b0; halt = 1'b0; resume = 1'b0; branch = 1'b0;
        baddr = '0; stall = 1'b0; ack = 1'b0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            #1;
            check(i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

endmodule
